// File: rtl/max_pool_stream_if.sv
// Pixel-in / pooled-out stream bundle for max_pool_stream; the master side supplies pixels.
interface max_pool_stream_if #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 1
);
  logic                         valid_in;
  logic [CHANNELS*DATA_W-1:0]   pixel_in;
  logic [CHANNELS*DATA_W-1:0]   maxpool_out;
  logic                         valid_out_maxpool;
  logic                         frame_done;

  modport master (
    output valid_in, pixel_in,
    input  maxpool_out, valid_out_maxpool, frame_done
  );

  modport slave (
    input  valid_in, pixel_in,
    output maxpool_out, valid_out_maxpool, frame_done
  );
endinterface

// File: rtl/max_pool_stream.sv
// Streaming POOLxPOOL max pooling, 1 clk latency, no backpressure (input accepted whenever valid).
// MAX_POOL_SIGNED_EN selects signed per-channel compares; unsigned when undefined.
module max_pool_stream #(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 1,
  parameter int POOL     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  max_pool_stream_if.slave  bus
);
  localparam int OW  = IMG_W / POOL;
  localparam int OH  = IMG_H / POOL;
  localparam int PW  = CHANNELS * DATA_W;
  localparam int CW  = $clog2(IMG_W + 1);
  localparam int RW  = $clog2(IMG_H + 1);
  localparam int PHW = $clog2(POOL);
  localparam int BW  = (OW > 1) ? $clog2(OW) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   col_cnt;
  logic [RW-1:0]   row_cnt;
  logic [PHW-1:0]  hph, vph;
  logic [BW-1:0]   wcol;
  logic [PW-1:0]   run_max;
  logic [PW-1:0]   buffer [OW];
  logic [PW-1:0]   maxpool_q;
  logic            valid_q;
  logic            frame_done_c;

  logic            accept, last_col, last_row, in_col, in_row;
  logic            last_col_win, last_row_win, win_done;
  logic [PW-1:0]   pix_max, row_max;

  function automatic logic [PW-1:0] vmax(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] r;
    r = b;
    for (int ch = 0; ch < CHANNELS; ch++) begin
`ifdef MAX_POOL_SIGNED_EN
      if ($signed(a[ch*DATA_W +: DATA_W]) > $signed(b[ch*DATA_W +: DATA_W]))
`else
      if (a[ch*DATA_W +: DATA_W] > b[ch*DATA_W +: DATA_W])
`endif
        r[ch*DATA_W +: DATA_W] = a[ch*DATA_W +: DATA_W];
    end
    return r;
  endfunction

  assign accept       = bus.valid_in;
  assign last_col     = (col_cnt == CW'(IMG_W - 1));
  assign last_row     = (row_cnt == RW'(IMG_H - 1));
  assign in_col       = (col_cnt < CW'(OW * POOL));
  assign in_row       = (row_cnt < RW'(OH * POOL));
  assign last_col_win = (hph == PHW'(POOL - 1));
  assign last_row_win = (vph == PHW'(POOL - 1));
  assign win_done     = accept && in_col && in_row && last_col_win;

  // Window row 0 must not see stale buffer contents from the previous window row band.
  assign pix_max = (hph == '0) ? bus.pixel_in : vmax(run_max, bus.pixel_in);
  assign row_max = (vph == '0) ? pix_max : vmax(buffer[wcol], pix_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      hph       <= '0;
      vph       <= '0;
      wcol      <= '0;
      run_max   <= '0;
      maxpool_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= win_done && last_row_win;
      if (win_done && last_row_win)
        maxpool_q <= row_max;
      if (accept) begin
        if (in_col && in_row)
          run_max <= pix_max;
        if (last_col) begin
          col_cnt <= '0;
          hph     <= '0;
          wcol    <= '0;
          if (last_row) begin
            row_cnt <= '0;
            vph     <= '0;
          end else begin
            row_cnt <= row_cnt + 1'b1;
            if (in_row)
              vph <= last_row_win ? '0 : vph + 1'b1;
          end
        end else begin
          col_cnt <= col_cnt + 1'b1;
          if (in_col) begin
            hph <= last_col_win ? '0 : hph + 1'b1;
            if (last_col_win)
              wcol <= wcol + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (win_done)
      buffer[wcol] <= row_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    frame_done_c = 1'b0;
    unique case (state)
      IDLE:    if (accept) state_nxt = ACTIVE;
      ACTIVE:  if (accept && last_col && last_row) state_nxt = DONE;
      DONE: begin
        frame_done_c = 1'b1;
        state_nxt    = accept ? ACTIVE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.maxpool_out       = maxpool_q;
  assign bus.valid_out_maxpool = valid_q;
  assign bus.frame_done        = frame_done_c;
endmodule

// File: tb/tb_max_pool_stream.sv
// Scoreboard bench for max_pool_stream: 4x4/1ch, 5x5/1ch and 4x4/2ch instances, POOL=2.
module tb_max_pool_stream;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  max_pool_stream_if #(.DATA_W(8), .CHANNELS(1)) bus_a ();
  max_pool_stream_if #(.DATA_W(8), .CHANNELS(1)) bus_b ();
  max_pool_stream_if #(.DATA_W(8), .CHANNELS(2)) bus_c ();

  max_pool_stream #(.IMG_W(4), .IMG_H(4), .DATA_W(8), .CHANNELS(1), .POOL(2))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  max_pool_stream #(.IMG_W(5), .IMG_H(5), .DATA_W(8), .CHANNELS(1), .POOL(2))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  max_pool_stream #(.IMG_W(4), .IMG_H(4), .DATA_W(8), .CHANNELS(2), .POOL(2))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

  int vectors = 0;
  int miscompares = 0;
  int strobes = 0;
  int img_w [3] = '{4, 5, 4};
  int img_h [3] = '{4, 5, 4};
  int col [3];
  int row [3];
  logic [15:0] img [3][25];
  logic [15:0] last_out [3];
  logic [15:0] exp_q [$];

  function automatic logic [7:0] smax(input logic [7:0] a, input logic [7:0] b);
`ifdef MAX_POOL_SIGNED_EN
    return ($signed(a) > $signed(b)) ? a : b;
`else
    return (a > b) ? a : b;
`endif
  endfunction

  function automatic logic [15:0] win_max(input int w, input int c0, input int r0);
    logic [15:0] m, p;
    m = img[w][r0*img_w[w] + c0];
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        p = img[w][(r0+dr)*img_w[w] + c0 + dc];
        m[7:0]  = smax(m[7:0], p[7:0]);
        m[15:8] = smax(m[15:8], p[15:8]);
      end
    return m;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      col[i] = 0;
      row[i] = 0;
      last_out[i] = 16'h0;
    end
    exp_q.delete();
  endtask

  // One clock on instance w: drive (v, pix), predict, then check strobe, frame_done and data.
  task automatic cycle(input int w, input logic v, input logic [15:0] pix);
    logic ev, efd, gv, gfd;
    logic [15:0] ed, gd;
    int c, r;
    bus_a.valid_in = (w == 0) && v;  bus_a.pixel_in = pix[7:0];
    bus_b.valid_in = (w == 1) && v;  bus_b.pixel_in = pix[7:0];
    bus_c.valid_in = (w == 2) && v;  bus_c.pixel_in = pix;
    ev = 1'b0;
    efd = 1'b0;
    if (v) begin
      c = col[w];
      r = row[w];
      img[w][r*img_w[w] + c] = pix;
      if ((c % 2 == 1) && (r % 2 == 1) && (c < (img_w[w]/2)*2) && (r < (img_h[w]/2)*2)) begin
        ev = 1'b1;
        exp_q.push_back(win_max(w, c - 1, r - 1));
      end
      efd = (c == img_w[w] - 1) && (r == img_h[w] - 1);
      if (c == img_w[w] - 1) begin
        col[w] = 0;
        row[w] = (r == img_h[w] - 1) ? 0 : r + 1;
      end else begin
        col[w] = c + 1;
      end
    end
    @(posedge clk);
    #1;
    case (w)
      0:       begin gv = bus_a.valid_out_maxpool; gfd = bus_a.frame_done; gd = {8'h0, bus_a.maxpool_out}; end
      1:       begin gv = bus_b.valid_out_maxpool; gfd = bus_b.frame_done; gd = {8'h0, bus_b.maxpool_out}; end
      default: begin gv = bus_c.valid_out_maxpool; gfd = bus_c.frame_done; gd = bus_c.maxpool_out; end
    endcase
    bus_a.valid_in = 1'b0;
    bus_b.valid_in = 1'b0;
    bus_c.valid_in = 1'b0;
    if (gv) strobes++;
    vectors++;
    if (gv !== ev) begin
      miscompares++;
      $display("FAIL strobe dut%0d: got %b expected %b at t=%0t", w, gv, ev, $time);
    end
    vectors++;
    if (gfd !== efd) begin
      miscompares++;
      $display("FAIL frame_done dut%0d: got %b expected %b at t=%0t", w, gfd, efd, $time);
    end
    if (ev && exp_q.size() > 0) begin
      ed = exp_q.pop_front();
      last_out[w] = ed;
    end else begin
      ed = last_out[w];
    end
    vectors++;
    if (gd !== ed) begin
      miscompares++;
      $display("FAIL data dut%0d: got %h expected %h at t=%0t", w, gd, ed, $time);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_a.valid_in = 1'b0; bus_a.pixel_in = '0;
    bus_b.valid_in = 1'b0; bus_b.pixel_in = '0;
    bus_c.valid_in = 1'b0; bus_c.pixel_in = '0;
    model_clear();
    @(posedge clk);
    #1;
    vectors++;
    if ({bus_a.maxpool_out, bus_a.valid_out_maxpool, bus_a.frame_done} !== 10'h0) begin
      miscompares++;
      $display("FAIL reset dut0: got %h/%b/%b expected 0", bus_a.maxpool_out, bus_a.valid_out_maxpool, bus_a.frame_done);
    end
    vectors++;
    if ({bus_b.maxpool_out, bus_b.valid_out_maxpool, bus_b.frame_done} !== 10'h0) begin
      miscompares++;
      $display("FAIL reset dut1: got %h/%b/%b expected 0", bus_b.maxpool_out, bus_b.valid_out_maxpool, bus_b.frame_done);
    end
    vectors++;
    if ({bus_c.maxpool_out, bus_c.valid_out_maxpool, bus_c.frame_done} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset dut2: got %h/%b/%b expected 0", bus_c.maxpool_out, bus_c.valid_out_maxpool, bus_c.frame_done);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_raster();
    int s0;
    s0 = strobes;
    for (int k = 0; k < 16; k++) cycle(0, 1'b1, 16'(k));
    cycle(0, 1'b0, 16'h0);
    vectors++;
    if (strobes - s0 != 4) begin
      miscompares++;
      $display("FAIL raster count: got %0d expected 4", strobes - s0);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 16; k++) cycle(0, 1'b1, 16'(k * 3));
    for (int k = 0; k < 16; k++) cycle(0, 1'b1, 16'(15 - k));
    cycle(0, 1'b0, 16'h0);
    vectors++;
    if (bus_a.maxpool_out !== 8'd5) begin
      miscompares++;
      $display("FAIL b2b last: got %h expected 05", bus_a.maxpool_out);
    end
  endtask

  task automatic test_gaps();
    for (int k = 0; k < 16; k++) begin
      cycle(0, 1'b1, 16'(k));
      for (int g = 0; g < 3; g++) cycle(0, 1'b0, 16'hAA);
    end
  endtask

  task automatic test_remainder();
    int s0;
    s0 = strobes;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) cycle(1, 1'b1, 16'((i + j) % 2));
    cycle(1, 1'b0, 16'h0);
    vectors++;
    if (strobes - s0 != 4 || bus_b.maxpool_out !== 8'd1) begin
      miscompares++;
      $display("FAIL remainder: got %0d strobes last %h expected 4 strobes last 01", strobes - s0, bus_b.maxpool_out);
    end
  endtask

  task automatic test_channels();
    for (int k = 0; k < 16; k++) cycle(2, 1'b1, {8'(15 - k), 8'(k)});
    cycle(2, 1'b0, 16'h0);
    vectors++;
    if (bus_c.maxpool_out !== 16'h050F) begin
      miscompares++;
      $display("FAIL channels last: got %h expected 050f", bus_c.maxpool_out);
    end
  endtask

  task automatic test_mid_reset();
    int s0;
    for (int k = 0; k < 6; k++) cycle(0, 1'b1, 16'(k + 100));
    test_reset();
    s0 = strobes;
    for (int k = 0; k < 16; k++) cycle(0, 1'b1, 16'(k));
    vectors++;
    if (strobes - s0 != 4) begin
      miscompares++;
      $display("FAIL mid_reset count: got %0d expected 4", strobes - s0);
    end
  endtask

  task automatic test_signed();
    logic [7:0] first;
`ifdef MAX_POOL_SIGNED_EN
    first = 8'h01;
`else
    first = 8'hFF;
`endif
    for (int k = 0; k < 16; k++) begin
      cycle(0, 1'b1, (k == 0) ? 16'h01 : 16'hFF);
      if (k == 5) begin
        vectors++;
        if (bus_a.maxpool_out !== first) begin
          miscompares++;
          $display("FAIL signed first: got %h expected %h", bus_a.maxpool_out, first);
        end
      end
    end
    cycle(0, 1'b0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_raster();
    test_back_to_back();
    test_gaps();
    test_remainder();
    test_channels();
    test_mid_reset();
    test_signed();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/max_pool_stream.md
Name: max_pool_stream

Overview:
- Parametrised streaming max-pooling block for the MNIST inference pipeline; the multi-bit, multi-channel successor to the 1-bit max-pooling stage.
- Takes one raster-order pixel vector per accepted cycle (all channels in parallel) from the conv/activation stage.
- Performs non-overlapping POOL x POOL max pooling (stride = POOL) using a row-partial buffer.
- Emits one pooled vector per window to the next layer, plus a frame-done pulse.

Parameters:
- IMG_W, 28, input image width in pixels (>= POOL)
- IMG_H, 28, input image height in pixels (>= POOL)
- DATA_W, 8, bits per channel sample
- CHANNELS, 1, channels processed in parallel, packed channel 0 in LSBs
- POOL, 2, window edge and stride (2..4)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- valid_in  input  1  pixel_in valid this cycle; no backpressure
- pixel_in  input  CHANNELS*DATA_W  packed input pixel, raster order
- maxpool_out  output  CHANNELS*DATA_W  packed pooled result, registered
- valid_out_maxpool  output  1  one-cycle strobe, maxpool_out valid
- frame_done  output  1  one-cycle pulse after last pixel of frame accepted

Behaviour:
- Reset: one clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values: maxpool_out=0, valid_out_maxpool=0, frame_done=0. Also cleared: col/row counters, window-phase counters, running max, buffer-valid state. FSM goes to IDLE.
- Reset mid-frame discards all partial windows. The next accepted pixel is treated as pixel (0,0).
- Counters advance only when valid_in=1. With valid_in=0, all state holds; gaps of any length are legal.
- col_cnt runs 0..IMG_W-1 and wraps, incrementing row_cnt. row_cnt runs 0..IMG_H-1.
- Pooled region: only pixels with col < (IMG_W/POOL)*POOL and row < (IMG_H/POOL)*POOL contribute. Trailing columns/rows (remainder) are consumed by the counters but ignored.
- Horizontal stage: a running per-channel max accumulates POOL consecutive pixels of a window row.
  - At the window's last column, it is combined with buffer[col/POOL].
  - Window row 0 ignores the buffer contents; other rows take max(buffer, running max).
  - The result is written back to buffer[col/POOL].
- Buffer depth: IMG_W/POOL entries x CHANNELS*DATA_W bits.
- Output: on the pixel completing a window (last col and last row of the window), maxpool_out is registered with the final per-channel max. valid_out_maxpool=1 for exactly the next cycle.
- Latency: 1 clk from the accepting edge.
- Output order is raster order of windows. Count per frame = (IMG_W/POOL)*(IMG_H/POOL).
- maxpool_out holds its last value when valid_out_maxpool=0.
- Comparison: per channel, independent, unsigned by default. Ties give the equal value. No width growth.
- FSM:
  - IDLE: no pixel of current frame accepted. valid_in=1 -> ACTIVE, processes that pixel as (0,0).
  - ACTIVE: accepting the frame. The pixel at (IMG_W-1, IMG_H-1) accepted -> DONE.
  - DONE: frame_done=1 for one cycle, counters already wrapped to 0 -> IDLE. valid_in=1 in DONE is accepted as pixel (0,0) of the next frame and goes to ACTIVE.
- Back-to-back frames with no gap are supported without loss.
- A last window coinciding with the last pixel gives valid_out_maxpool and frame_done in the same cycle.

Optional Feature:
- Macro: MAX_POOL_SIGNED_EN.
- Defined: each channel sample is two's-complement; comparisons are signed (0xFF = -1 < 0x01).
- Undefined: unsigned comparison (0xFF > 0x01).
- The macro affects only the compare; datapath width and timing are identical.

Test Plan:
- IMG_W=IMG_H=4, DATA_W=8, CH=1, POOL=2; pixels 0..15 raster, valid_in continuous -> outputs 5, 7, 13, 15, each 1 clk after pixels 5, 7, 13, 15; frame_done 1 clk after pixel 15, coincident with the output for 15.
- IMG_W=IMG_H=5, POOL=2, checkerboard (i+j)%2 -> exactly 4 outputs, all 1; row 4/col 4 ignored; frame_done after 25th pixel.
- Same 4x4 with valid_in low 3 cycles between every pixel -> identical 4 values, each 1 clk after its completing pixel; no spurious strobes in gaps.
- CH=2, 4x4, ch0 = 0..15, ch1 = 15..0 -> packed outputs {ch1,ch0} = {15,5}, {13,7}, {7,13}, {5,15}.
- rst_n low for 1 cycle after 6 pixels of a 4x4 frame, then full frame 0..15 -> only 5, 7, 13, 15 produced; no output from the aborted partial frame.
- 4x4, pixels 0xFF except 0x01 at (0,0) -> first output 0xFF without MAX_POOL_SIGNED_EN; with it, first output 0x01.
